// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA pixel-stream stages.
package vga_pkg;

    localparam int VGA_HDISP = 640;
    localparam int VGA_VDISP = 480;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

    typedef struct packed {
        rgb888_t rgb;
        logic    blank;
        logic    hs;
        logic    vs;
    } vga_px_t;

    // Bitwise colour inversion used by the XOR cursor mode.
    function automatic rgb888_t rgb_invert(input rgb888_t c);
        return rgb888_t'(~c);
    endfunction

    // True when pos lies in [start, start+len); 12-bit math keeps start+len from wrapping.
    function automatic logic in_span(input logic [11:0] pos, input logic [11:0] start,
                                     input logic [11:0] len);
        return (pos >= start) && (pos < (start + len));
    endfunction

    // True when pos is the first or last coordinate of [start, start+len).
    function automatic logic on_border(input logic [11:0] pos, input logic [11:0] start,
                                       input logic [11:0] len);
        return (pos == start) || (pos == (start + len - 12'd1));
    endfunction

endpackage

// File: rtl/vga_pos_tracker.sv
// Rebuilds the pixel coordinates from blank/vsync edges and flags frame boundaries.
module vga_pos_tracker
    import vga_pkg::*;
#(
    parameter int VDISP = VGA_VDISP
) (
    input  logic        vga_CLK,
    input  logic        rst,
    input  logic        blank_i,
    input  logic        vs_i,
    output logic [10:0] x_o,
    output logic [9:0]  y_o,
    output logic        vs_fall_o,
    output logic        synced_o,
    output logic        frame_start_o
);

    localparam logic [9:0] Y_LAST = 10'(VDISP - 1);

    logic        blank_prev_q;
    logic        vs_prev_q;
    logic [10:0] x_q, x_d;
    logic [9:0]  y_q, y_d;
    logic        synced_q, synced_d;
    logic        frame_start_q;
    logic        blank_fall;
    logic        vs_fall;

    assign blank_fall = blank_prev_q & ~blank_i;
    assign vs_fall    = vs_prev_q & ~vs_i;

    // Coordinate and sync-flag next state; vs_fall overrides the line increment.
    always_comb begin
        x_d      = x_q;
        y_d      = y_q;
        synced_d = synced_q;
        if (blank_fall) begin
            x_d = 11'd0;
        end else if (blank_i) begin
            x_d = x_q + 11'd1;
        end else begin
            x_d = x_q;
        end
        if (vs_fall) begin
            y_d = 10'd0;
        end else if (blank_fall && (y_q != Y_LAST)) begin
            y_d = y_q + 10'd1;
        end else begin
            y_d = y_q;
        end
        if (vs_fall) begin
            synced_d = 1'b1;
        end else begin
            synced_d = synced_q;
        end
    end

    // State registers; previous vsync resets high so an idle bus gives no false edge.
    always_ff @(posedge vga_CLK or posedge rst) begin
        if (rst) begin
            blank_prev_q  <= 1'b0;
            vs_prev_q     <= 1'b1;
            x_q           <= 11'd0;
            y_q           <= 10'd0;
            synced_q      <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            blank_prev_q  <= blank_i;
            vs_prev_q     <= vs_i;
            x_q           <= x_d;
            y_q           <= y_d;
            synced_q      <= synced_d;
            frame_start_q <= vs_fall;
        end
    end

    assign x_o           = x_q;
    assign y_o           = y_q;
    assign vs_fall_o     = vs_fall;
    assign synced_o      = synced_q;
    assign frame_start_o = frame_start_q;

endmodule

// File: rtl/vga_cursor_overlay.sv
// Two-stage pixel pipeline that overlays a frame-synchronous, optionally blinking cursor box.
module vga_cursor_overlay
    import vga_pkg::*;
#(
    parameter int HDISP        = VGA_HDISP,
    parameter int VDISP        = VGA_VDISP,
    parameter int CUR_SIZE     = 16,
    parameter int FILLED       = 1,
    parameter int BLINK_FRAMES = 30
) (
    input  logic        vga_CLK,
    input  logic        rst,
    input  logic [7:0]  in_r,
    input  logic [7:0]  in_g,
    input  logic [7:0]  in_b,
    input  logic        in_blank,
    input  logic        in_hs,
    input  logic        in_vs,
    input  logic [10:0] cur_x,
    input  logic [10:0] cur_y,
    input  logic        cur_en,
    input  logic        cur_xor,
    input  logic [23:0] cur_color,
    output logic [7:0]  out_r,
    output logic [7:0]  out_g,
    output logic [7:0]  out_b,
    output logic        out_blank,
    output logic        out_hs,
    output logic        out_vs,
    output logic        frame_start
);

    localparam logic [11:0] SIZE12     = 12'(CUR_SIZE);
    localparam logic [11:0] HLIM12     = 12'(HDISP);
    localparam logic [11:0] VLIM12     = 12'(VDISP);
    localparam logic [15:0] BLINK_LAST = 16'(BLINK_FRAMES - 1);
    localparam vga_px_t     PX_IDLE    = {24'h000000, 1'b0, 1'b1, 1'b1};

    logic [10:0] x_s;
    logic [9:0]  y_s;
    logic        vs_fall_s;
    logic        synced_s;

    logic [10:0] sx_q, sx_d, sy_q, sy_d;
    logic        en_q, en_d, xor_q, xor_d;
    rgb888_t     color_q, color_d;
    logic [15:0] blink_cnt_q, blink_cnt_d;
    logic        visible_q, visible_d;

    vga_px_t     px1_q, px1_d, px2_q, px2_d;
    logic        hit1_q, hit1_d;
    logic [11:0] x12, y12, sx12, sy12;
    logic        shape_ok;

    vga_pos_tracker #(
        .VDISP(VDISP)
    ) u_pos (
        .vga_CLK      (vga_CLK),
        .rst          (rst),
        .blank_i      (in_blank),
        .vs_i         (in_vs),
        .x_o          (x_s),
        .y_o          (y_s),
        .vs_fall_o    (vs_fall_s),
        .synced_o     (synced_s),
        .frame_start_o(frame_start)
    );

    // Shadow cursor settings and blink phase change only at the frame boundary.
    always_comb begin
        sx_d        = sx_q;
        sy_d        = sy_q;
        en_d        = en_q;
        xor_d       = xor_q;
        color_d     = color_q;
        blink_cnt_d = blink_cnt_q;
        visible_d   = visible_q;
        if (vs_fall_s) begin
            sx_d    = cur_x;
            sy_d    = cur_y;
            en_d    = cur_en;
            xor_d   = cur_xor;
            color_d = rgb888_t'(cur_color);
            if (BLINK_FRAMES == 0) begin
                blink_cnt_d = 16'd0;
                visible_d   = 1'b1;
            end else if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = 16'd0;
                visible_d   = ~visible_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 16'd1;
                visible_d   = visible_q;
            end
        end else begin
            blink_cnt_d = blink_cnt_q;
            visible_d   = visible_q;
        end
    end

    // Stage 1: capture the pixel and decide whether it falls inside the cursor box.
    always_comb begin
        x12  = {1'b0, x_s};
        y12  = {2'b00, y_s};
        sx12 = {1'b0, sx_q};
        sy12 = {1'b0, sy_q};
        if (FILLED != 0) begin
            shape_ok = 1'b1;
        end else begin
            shape_ok = on_border(x12, sx12, SIZE12) || on_border(y12, sy12, SIZE12);
        end
        hit1_d = synced_s & en_q & visible_q & in_blank
               & in_span(x12, sx12, SIZE12) & (x12 < HLIM12)
               & in_span(y12, sy12, SIZE12) & (y12 < VLIM12)
               & shape_ok;
        px1_d.rgb.r = in_r;
        px1_d.rgb.g = in_g;
        px1_d.rgb.b = in_b;
        px1_d.blank = in_blank;
        px1_d.hs    = in_hs;
        px1_d.vs    = in_vs;
    end

    // Stage 2: replace or invert the colour of hit pixels; timing bits pass straight through.
    always_comb begin
        px2_d = px1_q;
        if (hit1_q) begin
            if (xor_q) begin
                px2_d.rgb = rgb_invert(px1_q.rgb);
            end else begin
                px2_d.rgb = color_q;
            end
        end else begin
            px2_d.rgb = px1_q.rgb;
        end
    end

    // Pipeline, shadow and blink registers.
    always_ff @(posedge vga_CLK or posedge rst) begin
        if (rst) begin
            sx_q        <= 11'd0;
            sy_q        <= 11'd0;
            en_q        <= 1'b0;
            xor_q       <= 1'b0;
            color_q     <= 24'h000000;
            blink_cnt_q <= 16'd0;
            visible_q   <= 1'b1;
            px1_q       <= PX_IDLE;
            hit1_q      <= 1'b0;
            px2_q       <= PX_IDLE;
        end else begin
            sx_q        <= sx_d;
            sy_q        <= sy_d;
            en_q        <= en_d;
            xor_q       <= xor_d;
            color_q     <= color_d;
            blink_cnt_q <= blink_cnt_d;
            visible_q   <= visible_d;
            px1_q       <= px1_d;
            hit1_q      <= hit1_d;
            px2_q       <= px2_d;
        end
    end

    assign out_r     = px2_q.rgb.r;
    assign out_g     = px2_q.rgb.g;
    assign out_b     = px2_q.rgb.b;
    assign out_blank = px2_q.blank;
    assign out_hs    = px2_q.hs;
    assign out_vs    = px2_q.vs;

endmodule

// File: tb/tb_vga_cursor_overlay.sv
// Bench for vga_cursor_overlay: a scaled-down raster drives two instances (filled/no-blink and
// outline/blink-2) and every output is compared with a coordinate-level reference model.
module tb_vga_cursor_overlay;

    localparam int HD = 32, VD = 24, CS = 6;
    localparam int HTOT = 40, VTOT = 28;
    localparam int HS_START = 34, HS_END = 38;
    localparam int VS_START = 25, VS_END = 27;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_r, in_g, in_b;
    logic        in_blank, in_hs, in_vs;
    logic [10:0] cur_x, cur_y;
    logic        cur_en, cur_xor;
    logic [23:0] cur_color;
    logic [7:0]  a_r, a_g, a_b, b_r, b_g, b_b;
    logic        a_blank, a_hs, a_vs, a_fs, b_blank, b_hs, b_vs, b_fs;

    always #5 clk = ~clk;

    vga_cursor_overlay #(.HDISP(HD), .VDISP(VD), .CUR_SIZE(CS), .FILLED(1), .BLINK_FRAMES(0)) dut_a (
        .vga_CLK(clk), .rst(rst), .in_r(in_r), .in_g(in_g), .in_b(in_b), .in_blank(in_blank),
        .in_hs(in_hs), .in_vs(in_vs), .cur_x(cur_x), .cur_y(cur_y), .cur_en(cur_en),
        .cur_xor(cur_xor), .cur_color(cur_color), .out_r(a_r), .out_g(a_g), .out_b(a_b),
        .out_blank(a_blank), .out_hs(a_hs), .out_vs(a_vs), .frame_start(a_fs));

    vga_cursor_overlay #(.HDISP(HD), .VDISP(VD), .CUR_SIZE(CS), .FILLED(0), .BLINK_FRAMES(2)) dut_b (
        .vga_CLK(clk), .rst(rst), .in_r(in_r), .in_g(in_g), .in_b(in_b), .in_blank(in_blank),
        .in_hs(in_hs), .in_vs(in_vs), .cur_x(cur_x), .cur_y(cur_y), .cur_en(cur_en),
        .cur_xor(cur_xor), .cur_color(cur_color), .out_r(b_r), .out_g(b_g), .out_b(b_b),
        .out_blank(b_blank), .out_hs(b_hs), .out_vs(b_vs), .frame_start(b_fs));

    // Reference model state
    int          checks = 0, failures = 0;
    int          line = 0, col = 0;
    bit          rst_cmd = 1'b1;
    bit          synced = 1'b0, prev_vs = 1'b1, fall_last = 1'b0;
    int          nfall = 0;
    int          sh_x = 0, sh_y = 0;
    bit          sh_en = 1'b0, sh_xor = 1'b0;
    logic [23:0] sh_col = 24'h0;
    bit          pix_fixed_mode = 1'b0;
    logic [23:0] pix_fixed = 24'h0;
    logic [26:0] qa[$], qb[$];

    // Cursor coverage of pixel (x,y) for an instance with the given shape and blink period.
    function automatic bit model_hit(int filled, int blink, int x, int y);
        bit vis;
        vis = (blink == 0) ? 1'b1 : (((nfall / blink) % 2) == 0);
        if (!synced || !sh_en || !vis) return 1'b0;
        if (x < sh_x || x >= sh_x + CS || y < sh_y || y >= sh_y + CS) return 1'b0;
        if (filled != 0) return 1'b1;
        return (x == sh_x) || (x == sh_x + CS - 1) || (y == sh_y) || (y == sh_y + CS - 1);
    endfunction

    // One pixel clock: check outputs due now, then drive the next raster position.
    task automatic step();
        logic [23:0] pix, ra, rb;
        logic [26:0] ea, eb;
        bit act, ha, hb;
        @(negedge clk);
        if (!rst) begin
            checks++;
            if (a_fs !== fall_last) begin
                failures++;
                $display("FAIL frame_start_a t=%0t got=%b exp=%b", $time, a_fs, fall_last);
            end
            checks++;
            if (b_fs !== fall_last) begin
                failures++;
                $display("FAIL frame_start_b t=%0t got=%b exp=%b", $time, b_fs, fall_last);
            end
            if (qa.size() == 2) begin
                ea = qa.pop_front();
                eb = qb.pop_front();
                checks++;
                if ({a_r, a_g, a_b, a_blank, a_hs, a_vs} !== ea) begin
                    failures++;
                    $display("FAIL pixel_a t=%0t got=%h exp=%h", $time, {a_r, a_g, a_b, a_blank, a_hs, a_vs}, ea);
                end
                checks++;
                if ({b_r, b_g, b_b, b_blank, b_hs, b_vs} !== eb) begin
                    failures++;
                    $display("FAIL pixel_b t=%0t got=%h exp=%h", $time, {b_r, b_g, b_b, b_blank, b_hs, b_vs}, eb);
                end
            end
        end
        rst      = rst_cmd;
        act      = (line < VD) && (col < HD);
        pix      = act ? (pix_fixed_mode ? pix_fixed : 24'($urandom())) : 24'h0;
        {in_r, in_g, in_b} = pix;
        in_blank = act;
        in_hs    = !(col >= HS_START && col < HS_END);
        in_vs    = !(line >= VS_START && line < VS_END);
        if (rst_cmd) begin
            qa.delete();
            qb.delete();
            synced = 1'b0; nfall = 0; sh_en = 1'b0; prev_vs = 1'b1; fall_last = 1'b0;
        end else begin
            ha = act && model_hit(1, 0, col, line);
            hb = act && model_hit(0, 2, col, line);
            ra = ha ? (sh_xor ? ~pix : sh_col) : pix;
            rb = hb ? (sh_xor ? ~pix : sh_col) : pix;
            qa.push_back({ra, in_blank, in_hs, in_vs});
            qb.push_back({rb, in_blank, in_hs, in_vs});
            fall_last = prev_vs && !in_vs;
            if (fall_last) begin
                sh_x = int'(cur_x); sh_y = int'(cur_y);
                sh_en = cur_en; sh_xor = cur_xor; sh_col = cur_color;
                synced = 1'b1;
                nfall++;
            end
            prev_vs = in_vs;
        end
        col++;
        if (col == HTOT) begin
            col = 0;
            line = (line + 1 == VTOT) ? 0 : line + 1;
        end
    endtask

    task automatic run_to(int l, int c);
        for (int i = 0; i < HTOT * VTOT && !(line == l && col == c); i++) step();
    endtask

    task automatic run_frames(int n);
        for (int i = 0; i < n * HTOT * VTOT; i++) step();
    endtask

    task automatic set_cursor(int x, int y, bit en, bit xr, logic [23:0] c);
        cur_x = 11'(x); cur_y = 11'(y); cur_en = en; cur_xor = xr; cur_color = c;
    endtask

    task automatic test_reset();
        rst_cmd = 1'b1;
        for (int i = 0; i < 4; i++) step();
        #1;
        checks++;
        if ({a_r, a_g, a_b, a_blank, a_hs, a_vs, a_fs} !== {24'h0, 1'b0, 1'b1, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL reset_a got=%h exp=%h", {a_r, a_g, a_b, a_blank, a_hs, a_vs, a_fs}, {24'h0, 4'b0110});
        end
        checks++;
        if ({b_r, b_g, b_b, b_blank, b_hs, b_vs, b_fs} !== {24'h0, 1'b0, 1'b1, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL reset_b got=%h exp=%h", {b_r, b_g, b_b, b_blank, b_hs, b_vs, b_fs}, {24'h0, 4'b0110});
        end
        rst_cmd = 1'b0;
    endtask

    task automatic test_passthrough();
        set_cursor(10, 5, 1'b0, 1'b0, 24'hFFFFFF);
        pix_fixed_mode = 1'b0;
        run_to(0, 0);
        run_frames(1);
    endtask

    task automatic test_opaque_box();
        set_cursor(10, 5, 1'b1, 1'b0, 24'hFF0000);
        run_frames(2);
    endtask

    task automatic test_xor_outline();
        pix_fixed_mode = 1'b1;
        pix_fixed = 24'h123456;
        set_cursor(12, 7, 1'b1, 1'b1, 24'h00FF00);
        run_frames(2);
        pix_fixed_mode = 1'b0;
    endtask

    task automatic test_clipping();
        set_cursor(28, 20, 1'b1, 1'b0, 24'h0000FF);
        run_frames(2);
        set_cursor(40, 3, 1'b1, 1'b0, 24'h0000FF);
        run_frames(1);
        set_cursor(5, 30, 1'b1, 1'b1, 24'h0000FF);
        run_frames(1);
        set_cursor(31, 23, 1'b1, 1'b0, 24'hABCDEF);
        run_frames(1);
    endtask

    task automatic test_shadow_blink();
        for (int f = 0; f < 6; f++) begin
            run_to(10, 5);
            set_cursor($urandom_range(26, 0), $urandom_range(18, 0), 1'b1, 1'($urandom()),
                       24'($urandom()));
            run_to(VS_START + 1, 0);
        end
        run_to(0, 0);
    endtask

    task automatic test_reset_midframe();
        set_cursor(4, 4, 1'b1, 1'b0, 24'h00FFFF);
        run_frames(1);
        run_to(10, 15);
        rst_cmd = 1'b1;
        step();
        #1;
        checks++;
        if ({a_r, a_g, a_b, a_blank, a_hs, a_vs, a_fs} !== {24'h0, 1'b0, 1'b1, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL midreset_a got=%h exp=%h", {a_r, a_g, a_b, a_blank, a_hs, a_vs, a_fs}, {24'h0, 4'b0110});
        end
        checks++;
        if ({b_r, b_g, b_b, b_blank, b_hs, b_vs, b_fs} !== {24'h0, 1'b0, 1'b1, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL midreset_b got=%h exp=%h", {b_r, b_g, b_b, b_blank, b_hs, b_vs, b_fs}, {24'h0, 4'b0110});
        end
        for (int i = 0; i < 3; i++) step();
        rst_cmd = 1'b0;
        set_cursor(8, 12, 1'b1, 1'b0, 24'hFF00FF);
        run_frames(3);
    endtask

    task automatic test_random();
        for (int f = 0; f < 4; f++) begin
            set_cursor($urandom_range(40, 0), $urandom_range(30, 0), 1'($urandom_range(3, 0) != 0),
                       1'($urandom()), 24'($urandom()));
            run_frames(1);
        end
    endtask

    initial begin
        in_r = 8'h0; in_g = 8'h0; in_b = 8'h0;
        in_blank = 1'b0; in_hs = 1'b1; in_vs = 1'b1;
        set_cursor(0, 0, 1'b0, 1'b0, 24'h0);
        test_reset();
        test_passthrough();
        test_opaque_box();
        test_xor_outline();
        test_clipping();
        test_shadow_blink();
        test_reset_midframe();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
